// File: rtl/power_spectrum_fx_pkg.sv
// Shared sizing helpers for the fixed-point power-spectrum stage.
package power_spectrum_fx_pkg;

    // Ceiling log2. Returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            res = res + 1;
        end
        return res;
    endfunction

    // Number of one-sided bins (0..NFFT/2 inclusive).
    function automatic int nbin(input int nfft);
        return nfft / 2 + 1;
    endfunction

    // Width of the bin index carried alongside each output value.
    function automatic int bin_w(input int nfft);
        return clog2(nfft / 2) + 1;
    endfunction

endpackage

// File: rtl/power_spectrum_fx_avg_ram.sv
// Per-bin averager storage: one write port, one registered read port.
// Contents are deliberately left unreset; the first-frame logic never
// consumes a location before it has been written.
module power_spectrum_fx_avg_ram #(
    parameter int DEPTH = 257,
    parameter int WIDTH = 32,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write-then-registered-read memory, maps onto a simple dual-port block RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/power_spectrum_fx.sv
// Fixed-point power spectrum: P[k] = (re^2 + im^2) >> SCALE_SHIFT for the
// one-sided bins, optional per-bin exponential smoothing across frames.
// Four register stages from an accepted input beat to m_tvalid.
module power_spectrum_fx
    import power_spectrum_fx_pkg::*;
#(
    parameter int NFFT        = 512,
    parameter int DATA_W      = 16,
    parameter int POW_W       = 32,
    parameter int SCALE_SHIFT = 9,
    parameter int ALPHA_W     = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_tvalid,
    input  logic [2*DATA_W-1:0]    s_tdata,
    input  logic                   s_tlast,
    input  logic [ALPHA_W-1:0]     alpha_shift,
    input  logic                   avg_clr,
    output logic                   m_tvalid,
    output logic [POW_W-1:0]       m_tdata,
    output logic [bin_w(NFFT)-1:0] m_bin,
    output logic                   m_tlast,
    output logic                   err_tlast_unexp,
    output logic                   err_tlast_miss
);

    localparam int IDX_W  = clog2(NFFT);
    localparam int BIN_W  = bin_w(NFFT);
    localparam int NBIN   = nbin(NFFT);
    localparam int HALF   = NFFT / 2;
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam int EXT_W  = ((SUM_W > POW_W) ? SUM_W : POW_W) + 1;
    localparam logic [POW_W-1:0] POW_MAX = '1;

    // Input framing and frame-level control
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               err_unexp_q, err_miss_q;
    logic [ALPHA_W-1:0] alpha_q;
    logic               frame_first_q, first_frame_q, first_frame_d;
    logic               clr_pend_q, clr_pend_d;
    logic               idx_at_end, frame_start, bin_last_wr, first_eff;
    logic [ALPHA_W-1:0] tok_alpha;
    logic               tok_first;

    // Pipeline stages
    logic                     s1_v_q, s2_v_q, s3_v_q;
    logic signed [DATA_W-1:0] s1_re_q, s1_im_q;
    logic signed [PROD_W-1:0] s2_re2_q, s2_im2_q;
    logic [POW_W-1:0]         s3_p_q, s3_avg_q;
    logic [BIN_W-1:0]         s1_idx_q, s2_idx_q, s3_idx_q;
    logic [ALPHA_W-1:0]       s1_alpha_q, s2_alpha_q, s3_alpha_q;
    logic                     s1_first_q, s2_first_q, s3_first_q;
    logic [POW_W-1:0]         ram_rd_data;

    logic [SUM_W-1:0]         sum_d;
    logic [EXT_W-1:0]         shifted_d;
    logic [POW_W-1:0]         p_d;
    logic signed [POW_W:0]    diff_d, step_d, smooth_d;
    logic [POW_W-1:0]         out_d;

    logic                     out_v_q, out_last_q;
    logic [POW_W-1:0]         out_data_q;
    logic [BIN_W-1:0]         out_bin_q;

    // Index advance, frame start detection and the averager-reload bookkeeping
    always_comb begin
        idx_at_end  = (idx_q == IDX_W'(NFFT - 1));
        frame_start = s_tvalid && (idx_q == '0);
        bin_last_wr = s3_v_q && (s3_idx_q == BIN_W'(HALF));
        // A frame finishing its last bin on this very cycle no longer counts as first
        first_eff   = (first_frame_q && !bin_last_wr) || clr_pend_q;

        idx_d = idx_q;
        if (s_tvalid) begin
            idx_d = (idx_at_end || s_tlast) ? '0 : idx_q + 1'b1;
        end

        first_frame_d = first_frame_q;
        if (frame_start) begin
            first_frame_d = first_eff;
        end else if (bin_last_wr) begin
            first_frame_d = 1'b0;
        end

        clr_pend_d = frame_start ? avg_clr : (clr_pend_q || avg_clr);

        // Controls travel with each token so a short frame draining behind a new one keeps its own
        tok_alpha = frame_start ? alpha_shift : alpha_q;
        tok_first = frame_start ? first_eff : frame_first_q;
    end

    // Framing state, error pulses and per-frame latched controls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q         <= '0;
            err_unexp_q   <= 1'b0;
            err_miss_q    <= 1'b0;
            alpha_q       <= '0;
            frame_first_q <= 1'b1;
            first_frame_q <= 1'b1;
            clr_pend_q    <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            first_frame_q <= first_frame_d;
            clr_pend_q    <= clr_pend_d;
            err_unexp_q   <= s_tvalid && s_tlast && !idx_at_end;
            err_miss_q    <= s_tvalid && idx_at_end && !s_tlast;
            if (frame_start) begin
                alpha_q       <= alpha_shift;
                frame_first_q <= first_eff;
            end
        end
    end

    // Power computation and exponential smoothing datapath
    always_comb begin
        sum_d     = {1'b0, s2_re2_q} + {1'b0, s2_im2_q};
        shifted_d = EXT_W'(sum_d) >> SCALE_SHIFT;
        p_d       = (shifted_d > EXT_W'(POW_MAX)) ? POW_MAX : shifted_d[POW_W-1:0];

        diff_d   = $signed({1'b0, s3_p_q}) - $signed({1'b0, s3_avg_q});
        step_d   = diff_d >>> s3_alpha_q;
        smooth_d = $signed({1'b0, s3_avg_q}) + step_d;
        out_d    = ((s3_alpha_q == '0) || s3_first_q) ? s3_p_q : smooth_d[POW_W-1:0];
    end

    // Four-stage pipeline: capture, square, scale/saturate, smooth/output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q     <= 1'b0;
            s1_re_q    <= '0;
            s1_im_q    <= '0;
            s1_idx_q   <= '0;
            s1_alpha_q <= '0;
            s1_first_q <= 1'b0;
            s2_v_q     <= 1'b0;
            s2_re2_q   <= '0;
            s2_im2_q   <= '0;
            s2_idx_q   <= '0;
            s2_alpha_q <= '0;
            s2_first_q <= 1'b0;
            s3_v_q     <= 1'b0;
            s3_p_q     <= '0;
            s3_avg_q   <= '0;
            s3_idx_q   <= '0;
            s3_alpha_q <= '0;
            s3_first_q <= 1'b0;
            out_v_q    <= 1'b0;
            out_last_q <= 1'b0;
            out_data_q <= '0;
            out_bin_q  <= '0;
        end else begin
            // Bins above NFFT/2 are the mirrored half and never enter the pipe
            s1_v_q <= s_tvalid && (idx_q <= IDX_W'(HALF));
            if (s_tvalid) begin
                s1_re_q    <= s_tdata[DATA_W-1:0];
                s1_im_q    <= s_tdata[2*DATA_W-1:DATA_W];
                s1_idx_q   <= BIN_W'(idx_q);
                s1_alpha_q <= tok_alpha;
                s1_first_q <= tok_first;
            end

            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_re2_q   <= s1_re_q * s1_re_q;
                s2_im2_q   <= s1_im_q * s1_im_q;
                s2_idx_q   <= s1_idx_q;
                s2_alpha_q <= s1_alpha_q;
                s2_first_q <= s1_first_q;
            end

            s3_v_q <= s2_v_q;
            if (s2_v_q) begin
                s3_p_q     <= p_d;
                s3_avg_q   <= ram_rd_data;
                s3_idx_q   <= s2_idx_q;
                s3_alpha_q <= s2_alpha_q;
                s3_first_q <= s2_first_q;
            end

            out_v_q    <= s3_v_q;
            out_last_q <= bin_last_wr;
            if (s3_v_q) begin
                out_data_q <= out_d;
                out_bin_q  <= s3_idx_q;
            end
        end
    end

    power_spectrum_fx_avg_ram #(
        .DEPTH (NBIN),
        .WIDTH (POW_W),
        .AW    (BIN_W)
    ) u_avg_ram (
        .clk     (clk),
        .rd_en   (s1_v_q),
        .rd_addr (s1_idx_q),
        .rd_data (ram_rd_data),
        .wr_en   (s3_v_q),
        .wr_addr (s3_idx_q),
        .wr_data (out_d)
    );

    assign m_tvalid        = out_v_q;
    assign m_tdata         = out_data_q;
    assign m_bin           = out_bin_q;
    assign m_tlast         = out_last_q;
    assign err_tlast_unexp = err_unexp_q;
    assign err_tlast_miss  = err_miss_q;

endmodule

// File: tb/tb_power_spectrum_fx.sv
// Self-checking bench for power_spectrum_fx: table of constant-valued frames,
// directed framing/reset sequences, and randomized gapped frames against a
// cycle-stamped behavioural model of the output stream.
module tb_power_spectrum_fx;

    localparam int NFFT = 512;
    localparam int HALF = NFFT / 2;
    localparam int SS   = 9;
    localparam longint POWMAX = 64'd4294967295;

    logic        clk, rst;
    logic        s_tvalid, s_tlast, avg_clr;
    logic [31:0] s_tdata;
    logic [2:0]  alpha_shift;

    logic        m_tvalid, m_tlast, err_u, err_m;
    logic [31:0] m_tdata;
    logic [8:0]  m_bin;

    logic        sa_tvalid, sa_tlast, sa_eu, sa_em;
    logic [30:0] sa_tdata;
    logic [8:0]  sa_bin;
    logic        sb_tvalid, sb_tlast, sb_eu, sb_em;
    logic [31:0] sb_tdata;
    logic [8:0]  sb_bin;

    power_spectrum_fx dut (
        .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .alpha_shift(alpha_shift), .avg_clr(avg_clr), .m_tvalid(m_tvalid), .m_tdata(m_tdata),
        .m_bin(m_bin), .m_tlast(m_tlast), .err_tlast_unexp(err_u), .err_tlast_miss(err_m)
    );

    power_spectrum_fx #(.POW_W(31), .SCALE_SHIFT(0)) dut_sat31 (
        .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .alpha_shift(alpha_shift), .avg_clr(avg_clr), .m_tvalid(sa_tvalid), .m_tdata(sa_tdata),
        .m_bin(sa_bin), .m_tlast(sa_tlast), .err_tlast_unexp(sa_eu), .err_tlast_miss(sa_em)
    );

    power_spectrum_fx #(.POW_W(32), .SCALE_SHIFT(0)) dut_sat32 (
        .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .alpha_shift(alpha_shift), .avg_clr(avg_clr), .m_tvalid(sb_tvalid), .m_tdata(sb_tdata),
        .m_bin(sb_bin), .m_tlast(sb_tlast), .err_tlast_unexp(sb_eu), .err_tlast_miss(sb_em)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int     cyc;
        longint data;
        int     bin;
        bit     last;
    } exp_t;

    exp_t   expq[$];
    int     uq[$];
    int     mq[$];
    int     m_idx;
    bit     m_first, m_pend, f_first;
    int     f_alpha;
    longint avg_mem[NFFT/2+1];

    task automatic model_reset();
        m_idx = 0; m_first = 1; m_pend = 0; f_first = 1; f_alpha = 0;
        expq.delete(); uq.delete(); mq.delete();
    endtask

    // One accepted beat, stamped with the cycle its results must appear on
    task automatic model_beat(input int re, input int im, input bit last);
        longint s, p, o, d, q;
        if (m_idx == 0) begin
            f_alpha = int'(alpha_shift);
            f_first = m_first | m_pend;
            m_first = f_first;
            m_pend  = 0;
        end
        if (m_idx <= HALF) begin
            s = longint'(re) * re + longint'(im) * im;
            p = s >> SS;
            if (p > POWMAX) p = POWMAX;
            if (f_alpha == 0 || f_first) begin
                o = p;
            end else begin
                d = p - avg_mem[m_idx];
                q = longint'(1) << f_alpha;
                if (d >= 0) o = avg_mem[m_idx] + d / q;
                else        o = avg_mem[m_idx] - (-d + q - 1) / q;
            end
            avg_mem[m_idx] = o;
            expq.push_back('{cyc + 4, o, m_idx, m_idx == HALF});
            if (m_idx == HALF) m_first = 0;
        end
        if (last && m_idx != NFFT - 1) uq.push_back(cyc + 1);
        if (!last && m_idx == NFFT - 1) mq.push_back(cyc + 1);
        m_idx = (last || m_idx == NFFT - 1) ? 0 : m_idx + 1;
    endtask

    // ---------------- output monitor ----------------
    int     n_out, n_tlast, n_unexp, n_miss;
    longint obs0, obsn, sa_cap, sb_cap;

    task automatic clear_counts();
        n_out = 0; n_tlast = 0; n_unexp = 0; n_miss = 0;
        obs0 = -1; obsn = -1; sa_cap = -1; sb_cap = -1;
    endtask

    task automatic monitor_step();
        exp_t e;
        bit ev, eu, em;
        while (expq.size() > 0 && expq[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL out_missing bin=%0d actual=absent required=present", expq[0].bin);
            void'(expq.pop_front());
        end
        ev = (expq.size() > 0 && expq[0].cyc == cyc);
        chk("m_tvalid", m_tvalid, ev);
        if (ev) begin
            e = expq.pop_front();
            if (m_tvalid) begin
                chk("m_tdata", m_tdata, e.data);
                chk("m_bin", m_bin, e.bin);
                chk("m_tlast", m_tlast, e.last);
            end
        end
        if (m_tvalid) begin
            n_out++;
            if (m_tlast) n_tlast++;
            if (m_bin == 0) obs0 = m_tdata;
            if (m_bin == HALF) obsn = m_tdata;
        end
        while (uq.size() > 0 && uq[0] < cyc) void'(uq.pop_front());
        while (mq.size() > 0 && mq[0] < cyc) void'(mq.pop_front());
        eu = (uq.size() > 0 && uq[0] == cyc);
        em = (mq.size() > 0 && mq[0] == cyc);
        if (eu) void'(uq.pop_front());
        if (em) void'(mq.pop_front());
        chk("err_tlast_unexp", err_u, eu);
        chk("err_tlast_miss", err_m, em);
        if (err_u) n_unexp++;
        if (err_m) n_miss++;
        if (sa_tvalid && sa_bin == HALF) sa_cap = sa_tdata;
        if (sb_tvalid && sb_bin == HALF) sb_cap = sb_tdata;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && mon_en) monitor_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input int re, input int im, input bit last);
        s_tvalid = v;
        s_tdata  = {16'(im), 16'(re)};
        s_tlast  = last;
        if (v) model_beat(re, im, last);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0);
    endtask

    task automatic clr_pulse();
        avg_clr = 1'b1;
        m_pend  = 1;
        @(posedge clk);
        #1;
        avg_clr = 1'b0;
    endtask

    task automatic run_frame(input int len, input bit give_last, input bit rnd,
                             input int fre, input int fim, input bit gap);
        int re, im;
        for (int i = 0; i < len; i++) begin
            if (gap) begin
                while ($urandom_range(2) != 0) drive(0, 0, 0, 0);
            end
            re = rnd ? int'($urandom_range(65535)) - 32768 : fre;
            im = rnd ? int'($urandom_range(65535)) - 32768 : fim;
            drive(1, re, im, give_last && (i == len - 1));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_m_tvalid"}, m_tvalid, 0);
        chk({tag, "_m_tdata"}, m_tdata, 0);
        chk({tag, "_m_bin"}, m_bin, 0);
        chk({tag, "_m_tlast"}, m_tlast, 0);
        chk({tag, "_err_unexp"}, err_u, 0);
        chk({tag, "_err_miss"}, err_m, 0);
    endtask

    typedef struct {
        int     re;
        int     im;
        int     alpha;
        bit     clr;
        longint exp;
    } row_t;

    row_t tbl[9];

    initial begin
        // constant-valued frames; expected value holds for every bin of the frame
        tbl[0] = '{1000,     0, 0, 0, 1953};
        tbl[1] = '{1024,  1024, 2, 1, 4096};
        tbl[2] = '{   0,     0, 2, 0, 3072};
        tbl[3] = '{   0,     0, 2, 0, 2304};
        tbl[4] = '{ 226,     0, 2, 1,   99};
        tbl[5] = '{-1000,  500, 0, 0, 2441};
        tbl[6] = '{   0, -1000, 1, 0, 2197};
        tbl[7] = '{ 300,  -400, 3, 0, 1983};
        tbl[8] = '{1000,     0, 7, 0, 1982};

        rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
        alpha_shift = '0; avg_clr = 1'b0;
        model_reset();
        clear_counts();
        #1;
        check_reset_outputs("reset");
        #21;
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1;

        for (int r = 0; r < 9; r++) begin
            alpha_shift = 3'(tbl[r].alpha);
            if (tbl[r].clr) clr_pulse();
            clear_counts();
            run_frame(NFFT, 1, 0, tbl[r].re, tbl[r].im, 0);
            idle(8);
            chk("row_bin0", obs0, tbl[r].exp);
            chk("row_binN", obsn, tbl[r].exp);
            chk("row_count", n_out, HALF + 1);
            chk("row_tlast", n_tlast, 1);
            chk("row_errs", n_unexp + n_miss, 0);
            $display("row %0d re=%0d im=%0d a=%0d bin0=%0d binN=%0d", r, tbl[r].re, tbl[r].im,
                     tbl[r].alpha, obs0, obsn);
        end

        // saturation on the SCALE_SHIFT=0 instances
        alpha_shift = 3'd0;
        clear_counts();
        run_frame(NFFT, 1, 0, -32768, -32768, 0);
        idle(8);
        chk("sat_pow31", sa_cap, 64'h7FFFFFFF);
        chk("sat_pow32", sb_cap, 64'h80000000);
        $display("saturation frame pow31=%0h pow32=%0h", sa_cap, sb_cap);

        // tlast at idx 300, then a normal frame
        clear_counts();
        run_frame(301, 1, 1, 0, 0, 0);
        idle(8);
        chk("tlast300_unexp", n_unexp, 1);
        chk("tlast300_count", n_out, HALF + 1);
        $display("early tlast at 300: outputs=%0d unexp=%0d", n_out, n_unexp);
        clear_counts();
        run_frame(NFFT, 1, 1, 0, 0, 0);
        idle(8);
        chk("after300_count", n_out, HALF + 1);
        chk("after300_tlast", n_tlast, 1);

        // missing tlast at idx 511
        clear_counts();
        run_frame(NFFT, 0, 1, 0, 0, 0);
        idle(8);
        chk("miss_pulses", n_miss, 1);
        $display("missing tlast: miss=%0d", n_miss);

        // tlast at idx 100: frame ends without m_tlast
        alpha_shift = 3'd1;
        clear_counts();
        run_frame(101, 1, 1, 0, 0, 0);
        idle(8);
        chk("tlast100_count", n_out, 101);
        chk("tlast100_tlast", n_tlast, 0);
        chk("tlast100_unexp", n_unexp, 1);
        $display("early tlast at 100: outputs=%0d tlast=%0d", n_out, n_tlast);

        // randomized frames, gapped and gapless, random smoothing shift
        for (int f = 0; f < 3; f++) begin
            alpha_shift = 3'($urandom_range(7));
            clear_counts();
            run_frame(NFFT, 1, 1, 0, 0, f != 1);
            idle(8);
            chk("rand_count", n_out, HALF + 1);
            $display("random frame %0d a=%0d outputs=%0d", f, alpha_shift, n_out);
        end

        // asynchronous reset mid-frame
        alpha_shift = 3'd2;
        run_frame(105, 0, 1, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int f = 0; f < 2; f++) begin
            clear_counts();
            run_frame(NFFT, 1, 1, 0, 0, 0);
            idle(8);
            chk("postrst_count", n_out, HALF + 1);
            chk("postrst_tlast", n_tlast, 1);
            $display("post-reset frame %0d outputs=%0d", f, n_out);
        end

        chk("pending_outputs", expq.size(), 0);
        mon_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
